// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, BCD limits
// and the packed three-digit time value shared by the timer and its decrementer.
package timer_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RUNNING = 2'd1;
   localparam logic [1:0] PAUSED  = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] DEZ_MAX = 4'd5;

   typedef struct packed {
      logic [3:0] minutos;
      logic [3:0] dezena;
      logic [3:0] unidade;
   } bcdTime_t;

   // Microwave-style entry: digits enter on the right, the old minutes digit drops out.
   function automatic bcdTime_t shiftIn(input bcdTime_t t, input logic [3:0] d);
      bcdTime_t r;
      r.minutos = t.dezena;
      r.dezena  = t.unidade;
      r.unidade = d;
      return r;
   endfunction

   function automatic logic isZero(input bcdTime_t t);
      return (t == '0);
   endfunction

endpackage

// File: rtl/bcd_down3.sv
// Combinational one-second decrement of an M:SS BCD value with borrow rules,
// plus a flag telling whether the decremented value is 0:00.
module bcd_down3
   import timer_pkg::*;
(
   input  logic [3:0] minIn,
   input  logic [3:0] dezIn,
   input  logic [3:0] uniIn,
   output logic [3:0] minOut,
   output logic [3:0] dezOut,
   output logic [3:0] uniOut,
   output logic       isZeroNext
);

   // NOTE: every output gets a default before the branches so no latch is inferred.
   always_comb begin
      minOut = minIn;
      dezOut = dezIn;
      uniOut = uniIn;
      if (uniIn != 4'd0) begin
         uniOut = uniIn - 4'd1;
      end else begin
         uniOut = BCD_MAX;
         if (dezIn != 4'd0) begin
            dezOut = dezIn - 4'd1;
         end else begin
            // Tens wrap to 5, not 9: a minute holds sixty seconds.
            dezOut = DEZ_MAX;
            minOut = minIn - 4'd1;
         end
      end
      isZeroNext = (minOut == 4'd0) && (dezOut == 4'd0) && (uniOut == 4'd0);
   end

endmodule

// File: rtl/timer_bcd.sv
// Keypad-loaded M:SS countdown timer feeding the 7-segment decoder.
// Define TIMER_DONE_HOLD_EN to make DONE sticky until clear or a new digit.
module timer_bcd
   import timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int PRESC_W       = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [3:0] Minutos,
   output logic [3:0] DezenaSeg,
   output logic [3:0] UnidadeSeg,
   output logic       running,
   output logic       done
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

   logic [1:0]         state, stateNext;
   bcdTime_t           count, countNext, countDec;
   logic [PRESC_W-1:0] presc, prescNext;
   logic               secTick;
   logic               decIsZero;
   logic               digitState;

   bcd_down3 u_bcdDown3 (
      .minIn      (count.minutos),
      .dezIn      (count.dezena),
      .uniIn      (count.unidade),
      .minOut     (countDec.minutos),
      .dezOut     (countDec.dezena),
      .uniOut     (countDec.unidade),
      .isZeroNext (decIsZero)
   );

   assign secTick = (state == RUNNING) && (presc == PRESC_LAST);

`ifdef TIMER_DONE_HOLD_EN
   assign digitState = (state == IDLE) || (state == DONE);
`else
   assign digitState = (state == IDLE);
`endif

   always_comb begin
      stateNext = state;
      countNext = count;
      prescNext = presc;

      case (state)
         RUNNING: begin
            if (secTick) begin
               prescNext = '0;
               countNext = countDec;
               if (decIsZero) stateNext = DONE;
            end else begin
               prescNext = presc + PRESC_W'(1);
            end
         end
`ifndef TIMER_DONE_HOLD_EN
         DONE:    stateNext = IDLE;
`endif
         default: ;
      endcase

      // Only the highest-priority strobe present is considered; an ineffective
      // strobe still masks the lower ones and leaves the default behaviour above.
      if (clear) begin
         stateNext = IDLE;
         countNext = '0;
         prescNext = '0;
      end else if (pause) begin
         if (state == RUNNING) begin
            stateNext = PAUSED;
            countNext = count;
            prescNext = presc;
         end
      end else if (start) begin
         if (((state == IDLE) || (state == PAUSED)) && !isZero(count)) begin
            stateNext = RUNNING;
            prescNext = '0;
         end
      end else if (digit_valid) begin
         if (digitState && (digit <= BCD_MAX)) begin
            stateNext = IDLE;
            countNext = shiftIn(count, digit);
         end
      end
   end

   // NOTE: non-blocking assignments so every register samples the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         presc   <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= stateNext;
         count   <= countNext;
         presc   <= prescNext;
         running <= (stateNext == RUNNING);
         done    <= (stateNext == DONE);
      end
   end

   assign Minutos    = count.minutos;
   assign DezenaSeg  = count.dezena;
   assign UnidadeSeg = count.unidade;

endmodule
